ppv_flit_fifo: RTL and testbench
================================

// Module: ppv_flit_fifo
// PURPOSE
//  Parametrised single-clock flit FIFO for the hring fan-in/fan-out router input stage.
//  Head flit is first-word-fall-through (FWFT).
//  The switch allocator (SA) feeds back an unclaimed-port vector (uppv):
//  - uppv != 0 rewrites the head flit's PPV field in place; the flit stays at the head.
//  - uppv == 0 retires the head flit.
//  Adds full, almost-full, occupancy and sticky overflow/underflow error flags.
// PARAMETERS
//  DATA_W    `IR_DATA_WIDTH  flit width in bits
//  DEPTH     8               entries; power of two, >=2
//  NUM_PORT  `NUM_PORT       PPV width, one bit per output port
//  PPV_LSB   `PPV_START      bit index of PPV field LSB; PPV_LSB+NUM_PORT<=DATA_W
//  AF_LEVEL  DEPTH-2         almost_full asserted when count>=AF_LEVEL
// PORTS
//  clk          in   1                 clock, rising edge
//  rst          in   1                 asynchronous reset, active-high
//  wr_en        in   1                 push data_in this cycle
//  data_in      in   DATA_W            flit to push
//  rd_en        in   1                 SA evaluated the head flit this cycle
//  uppv         in   NUM_PORT          unclaimed ports of head flit; 0 = fully claimed
//  data_out     out  DATA_W            head flit (PPV field possibly overridden); valid when !empty
//  empty        out  1                 count==0
//  full         out  1                 count==DEPTH
//  almost_full  out  1                 count>=AF_LEVEL
//  count        out  $clog2(DEPTH)+1   occupancy
//  ovf_err      out  1                 sticky: push rejected while full
//  udf_err      out  1                 sticky: rd_en while empty
// BEHAVIOUR
//  Reset (async assert; deassert sampled on clk):
//  - pointers=0, count=0, ppv_ovr_vld=0, ovf_err=0, udf_err=0, empty=1, full=0, almost_full=0.
//  - data_out=0 while empty.
//  pop  = rd_en & !empty & (uppv==0).
//  upd  = rd_en & !empty & (uppv!=0).
//  push = wr_en & (!full | pop).
//  - Full with same-cycle pop accepts the push; count is unchanged.
//  push: mem[wr_ptr]<=data_in; wr_ptr++ (wraps mod DEPTH).
//  - data_out/empty reflect the pushed flit on the next cycle (1-cycle fall-through latency).
//  pop: rd_ptr++ (wraps); ppv_ovr_vld<=0. Next entry appears next cycle with its original PPV.
//  upd: ppv_ovr<=uppv; ppv_ovr_vld<=1; pointers and count unchanged.
//  - Repeated upd cycles overwrite ppv_ovr.
//  - uppv may carry bits not set in the current PPV; they are stored as given.
//  data_out = mem[rd_ptr], with bits [PPV_LSB+:NUM_PORT] replaced by ppv_ovr when ppv_ovr_vld.
//  - Combinational from registers only.
//  count: +1 on push&!pop; -1 on pop&!push; unchanged otherwise. Never exceeds DEPTH or goes below 0.
//  ovf_err<=1 on wr_en&full&!pop.
//  udf_err<=1 on rd_en&empty.
//  - Both sticky until rst. Rejected ops change no other state.
//  rd_en&empty ignores uppv; no upd occurs.
//  Push into an empty FIFO with simultaneous rd_en: rd_en sees empty=1 and is ignored.
//  Reset mid-operation discards all contents and the override; outputs go to reset values immediately.
// STRUCTURE
//  - Global defines (IR_DATA_WIDTH, NUM_PORT, PPV_START/PPV_END) stay in global.vh. No new typedefs.
//  - Sub-module ppv_fifo_ram: DEPTH x DATA_W register file, 1 sync write port, 1 async read port. No reset on storage.
//  - Top holds pointers, count, override register, flags. Count derived from count reg, not pointer difference.
// TESTING
//  1. Reset, then 4 pushes (0x11..0x44), rd_en uppv=0 x4 -> data_out 0x11,0x22,0x33,0x44 in order; empty=1; count 4->0.
//  2. Head PPV=4'b1011; rd_en uppv=4'b0010 -> data_out PPV=0010, count unchanged.
//     Then rd_en uppv=0 -> pop; next head carries its original PPV.
//  3. Push DEPTH=8 flits -> full=1, almost_full from count=6.
//     9th push alone -> rejected, ovf_err=1, count=8.
//     Push+pop at full -> count stays 8; the new flit is the last popped.
//  4. rd_en on empty -> udf_err=1, count 0, no state change.
//     Push with rd_en at empty -> count=1, not popped.
//  5. Fill 5, then 3 cycles of upd; assert rst mid-cycle -> empty=1, count=0, flags 0, override cleared.
//     Push 0xAB -> data_out=0xAB with original PPV.
//  6. 100 random push/pop/upd cycles vs scoreboard model, including pointer wrap -> no mismatch, no spurious error flags.

Source files
------------

// File: rtl/ppv_flit_fifo_pkg.sv
// Shared defaults for the hring router input-stage flit FIFO.
// Widths mirror the router-wide flit/PPV layout.
package ppv_flit_fifo_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_NUM_PORT = 4;
    localparam int DEF_PPV_LSB  = 8;
endpackage

// File: rtl/ppv_fifo_ram.sv
// Flit storage: DEPTH x DATA_W register file.
// One synchronous write port, one asynchronous read port, no reset.
module ppv_fifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ppv_flit_fifo.sv
// FWFT flit FIFO whose head PPV field can be rewritten in place
// by the switch allocator's unclaimed-port feedback.
module ppv_flit_fifo
    import ppv_flit_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_PORT = DEF_NUM_PORT,
    parameter int PPV_LSB  = DEF_PPV_LSB,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd_en,
    input  logic [NUM_PORT-1:0]      uppv,
    output logic [DATA_W-1:0]        data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_err,
    output logic                     udf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [NUM_PORT-1:0] ppv_ovr;
    logic                ppv_ovr_vld;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   head;
    logic                pop;
    logic                upd;
    logic                push;

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign almost_full = (count >= CW'(AF_LEVEL));

    assign pop  = rd_en & ~empty & ~(|uppv);
    assign upd  = rd_en & ~empty & (|uppv);
    // A pop frees the slot, so a full FIFO may still take a push.
    assign push = wr_en & (~full | pop);

    ppv_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_comb begin
        head = rd_data;
        if (ppv_ovr_vld) head[PPV_LSB+:NUM_PORT] = ppv_ovr;
        data_out = empty ? '0 : head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ppv_ovr     <= '0;
            ppv_ovr_vld <= 1'b0;
            ovf_err     <= 1'b0;
            udf_err     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (pop) begin
                ppv_ovr_vld <= 1'b0;
            end else if (upd) begin
                ppv_ovr     <= uppv;
                ppv_ovr_vld <= 1'b1;
            end
            if (wr_en && full && !pop) ovf_err <= 1'b1;
            if (rd_en && empty)        udf_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ppv_flit_fifo.sv
// Randomised and directed checks of ppv_flit_fifo against a queue model.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_ppv_flit_fifo;
    localparam int DATA_W   = 16;
    localparam int DEPTH    = 8;
    localparam int NUM_PORT = 4;
    localparam int PPV_LSB  = 4;
    localparam int AF_LEVEL = DEPTH - 2;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                wr_en = 1'b0;
    logic [DATA_W-1:0]   data_in = '0;
    logic                rd_en = 1'b0;
    logic [NUM_PORT-1:0] uppv = '0;
    logic [DATA_W-1:0]   data_out;
    logic                empty;
    logic                full;
    logic                almost_full;
    logic [CW-1:0]       count;
    logic                ovf_err;
    logic                udf_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0]   q [$];
    logic                m_vld;
    logic [NUM_PORT-1:0] m_ovr;
    logic                m_ovf;
    logic                m_udf;

    always #5 clk = ~clk;

    ppv_flit_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NUM_PORT (NUM_PORT),
        .PPV_LSB  (PPV_LSB),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .uppv        (uppv),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_vld = 1'b0;
        m_ovr = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] exp_head();
        logic [DATA_W-1:0] h;
        if (q.size() == 0) return '0;
        h = q[0];
        if (m_vld) h[PPV_LSB+:NUM_PORT] = m_ovr;
        return h;
    endfunction

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".dout"},  32'(data_out),    32'(exp_head()));
        chk({tag, ".count"}, 32'(count),       32'(n));
        chk({tag, ".empty"}, 32'(empty),       32'(n == 0));
        chk({tag, ".full"},  32'(full),        32'(n == DEPTH));
        chk({tag, ".af"},    32'(almost_full), 32'(n >= AF_LEVEL));
        chk({tag, ".ovf"},   32'(ovf_err),     32'(m_ovf));
        chk({tag, ".udf"},   32'(udf_err),     32'(m_udf));
    endtask

    // One clock: drive, advance the model by the same cycle, compare.
    task automatic cyc(input string tag, input logic w, input logic [DATA_W-1:0] d,
                       input logic r, input logic [NUM_PORT-1:0] u);
        int  n;
        bit  p;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        uppv    = u;
        n = q.size();
        p = r && n > 0 && u == 0;
        if (w && n == DEPTH && !p) m_ovf = 1'b1;
        if (r && n == 0)           m_udf = 1'b1;
        if (p) begin
            void'(q.pop_front());
            m_vld = 1'b0;
        end else if (r && n > 0) begin
            m_ovr = u;
            m_vld = 1'b1;
        end
        if (w && (n < DEPTH || p)) q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        uppv  = '0;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // In-order FWFT traffic.
        for (int i = 1; i <= 4; i++) cyc("t1push", 1, DATA_W'(i * 'h11), 0, 0);
        chk("t1head", 32'(data_out), 32'h11);
        for (int i = 0; i < 4; i++) cyc("t1pop", 0, 0, 1, 0);
        chk("t1empty", 32'(empty), 32'd1);

        // In-place PPV rewrite, then pop exposes original PPV of next.
        cyc("t2push", 1, 16'h12B5, 0, 0);
        cyc("t2push", 1, 16'h3C45, 0, 0);
        cyc("t2upd", 0, 0, 1, 4'b0010);
        chk("t2ovr", 32'(data_out), 32'h1225);
        cyc("t2upd2", 0, 0, 1, 4'b1100);
        cyc("t2pop", 0, 0, 1, 0);
        chk("t2next", 32'(data_out), 32'h3C45);
        cyc("t2pop", 0, 0, 1, 0);

        // Fill, overflow, push+pop at full.
        for (int i = 0; i < DEPTH; i++)
            cyc("t3fill", 1, DATA_W'(16'hA000 + i), 0, 0);
        cyc("t3ovf", 1, 16'hDEAD, 0, 0);
        chk("t3ovfflag", 32'(ovf_err), 32'd1);
        cyc("t3pp", 1, 16'hBEEF, 1, 0);
        chk("t3ppcnt", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cyc("t3drain", 0, 0, 1, 0);

        // Underflow and push-with-read into empty.
        cyc("t4udf", 0, 0, 1, 4'b0101);
        chk("t4udfflag", 32'(udf_err), 32'd1);
        cyc("t4pushrd", 1, 16'h0077, 1, 0);
        chk("t4cnt", 32'(count), 32'd1);
        cyc("t4pop", 0, 0, 1, 0);

        // Reset in the middle of a cycle with an override pending.
        for (int i = 0; i < 5; i++)
            cyc("t5fill", 1, DATA_W'(16'h50F0 + i), 0, 0);
        cyc("t5upd", 0, 0, 1, 4'b0001);
        cyc("t5upd", 0, 0, 1, 4'b0110);
        cyc("t5upd", 0, 0, 1, 4'b1111);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("t5rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("t5push", 1, 16'h00AB, 0, 0);
        chk("t5ab", 32'(data_out), 32'h00AB);

        // Random traffic with pointer wrap.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            logic                w;
            logic                r;
            logic [NUM_PORT-1:0] u;
            w = ($urandom_range(0, 99) < 55);
            r = (q.size() > 0) && ($urandom_range(0, 99) < 60);
            u = ($urandom_range(0, 2) == 0) ? NUM_PORT'($urandom) : '0;
            if (w && q.size() == DEPTH) w = r && u == 0;
            cyc("rand", w, DATA_W'($urandom), r, u);
        end
        chk("rand.noovf", 32'(ovf_err), 32'd0);
        chk("rand.noudf", 32'(udf_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
